gt_cfg_ctrl: RTL and testbench
==============================

// Module: gt_cfg_ctrl
// PURPOSE
//  Register-mapped producer of the per-lane gt_cfg_t transceiver config; drives the GT wrapper directly.
//  Software writes shadow registers; a COMMIT applies them to cfg_out atomically.
//  An FSM generates timed eyescanreset/rxreset pulses, including an automatic RX reset on DFE-mode change.
// PARAMETERS
//  RST_CYCLES      16       width of generated reset pulses, clk cycles (>=2)
//  DIFFCTRL_MAX    5'd24    txdiffctrl clamp ceiling; larger writes saturate
//  DIFFCTRL_RST    5'd12    reset value of txdiffctrl
//  RXDFEEN_RST     1'b1     reset value of rxdfeen
// PORTS
//  clk        in   1    sole clock
//  rst        in   1    synchronous, active-high reset
//  wr_en      in   1    register write strobe
//  wr_addr    in   3    write address
//  wr_data    in   32   write data
//  rd_en      in   1    register read strobe
//  rd_addr    in   3    read address
//  rd_data    out  32   read data, valid with rd_valid
//  rd_valid   out  1    one cycle after rd_en
//  cfg_out    out  22   gt_cfg_t (tx 5/5/5 + 7 single bits), registered
//  busy       out  1    FSM not in IDLE
// BEHAVIOUR
//  Map: 0 TX   [4:0]diffctrl [12:8]precursor [20:16]postcursor (shadow, R/W)
//       1 MISC [0]txpol [1]txinhibit [2]rxpol [3]rxinhibit [4]rxdfeen (shadow, R/W)
//       2 CTRL W: [0]commit [1]eyescan pulse [2]rxreset level (stored, reads back)
//       3 STAT R: [0]busy [1]commit_err (sticky; W1C on [1])
//       4/5 read active cfg_out TX/MISC fields; other addrs read 0, writes ignored.
//  Write to 0 with diffctrl>DIFFCTRL_MAX stores DIFFCTRL_MAX. Unused bits read 0.
//  Reset: shadow+active = DIFFCTRL_RST, pre/post 0, txinhibit 1, rxdfeen RXDFEEN_RST, other bits 0;
//   rxreset=1, eyescanreset=0, rd_valid=0, rd_data=0, commit_err=0, FSM->RX_RST.
//  FSM: IDLE, APPLY, RX_RST, ES_RST.
//   IDLE: commit -> APPLY; else eyescan bit -> ES_RST.
//   APPLY (1 cycle): active<=shadow; cfg_out visible 2 cycles after commit write;
//     if rxdfeen changed (auto-reset enabled) -> RX_RST, else IDLE.
//   RX_RST: rxreset=1 for exactly RST_CYCLES, counter from 0, then IDLE.
//   ES_RST: eyescanreset=1 for exactly RST_CYCLES, then IDLE.
//  rxreset output = FSM RX_RST OR CTRL[2] level; eyescanreset only from ES_RST.
//  Commit or eyescan request while busy: dropped, commit_err<=1, no state change.
//  Commit+eyescan in same write from IDLE: commit wins, eyescan dropped, commit_err<=1.
//  Shadow writes while busy are accepted; they never touch active until next commit.
//  Same-cycle W1C and new error: error wins (bit stays 1).
//  rst mid-pulse: counter cleared, outputs to reset values, FSM restarts RX_RST.
//  Read and write same address same cycle: read returns pre-write value.
// CONFIGURATION
//  GT_CFG_CTRL_AUTO_RXRESET_EN defined: APPLY enters RX_RST when committed rxdfeen
//   differs from previous active value.
//  Undefined: APPLY always returns to IDLE; RX reset only via CTRL[2] or rst.
// TESTING
//  rst 1 cycle -> rxreset high 16 cycles after release, busy high, then cfg_out = reset values.
//  wr 0 = 0x00_03_02_1F -> rd 0 = 0x00030218 (clamped 24); rd 4 unchanged until commit.
//  wr 2 = 1 in IDLE -> cfg_out updates on 2nd edge, busy 1 cycle, rxreset stays 0.
//  flip rxdfeen + commit, macro on -> rxreset 16 cycles after APPLY; macro off -> none.
//  wr 2 = 2 then wr 2 = 1 during ES_RST -> eyescanreset 16 cycles, STAT=0x3; wr 3=2 -> STAT=0x0.
//  assert rst at cycle 5 of ES_RST -> eyescanreset 0 next edge, RX_RST sequence restarts.

Source files
------------

// File: rtl/gt_cfg_ctrl.sv
// gt_cfg_ctrl: register-mapped GT lane config with atomic commit and timed reset pulses (GT_CFG_CTRL_AUTO_RXRESET_EN enables auto RX reset on DFE change)
module gt_cfg_ctrl #(
  parameter int         RST_CYCLES   = 16,
  parameter logic [4:0] DIFFCTRL_MAX = 5'd24,
  parameter logic [4:0] DIFFCTRL_RST = 5'd12,
  parameter logic       RXDFEEN_RST  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [21:0] cfg_out,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, APPLY, RX_RST, ES_RST} state_t;
  localparam int CW = $clog2(RST_CYCLES);
  localparam logic [4:0] MISC_RST = {RXDFEEN_RST, 4'b0010};
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [4:0] s_diff, s_pre, s_post, s_misc, a_diff, a_pre, a_post, a_misc;
  logic rx_bit, es_bit, ctrl_rx, ctrl_rx_n, err, err_n;
  logic wr_ctrl, commit, es_req, done, dfe_chg;
  logic [4:0] diff_w;
  logic [31:0] rd_mux;
  logic unused_bits;
  assign unused_bits = &{1'b0, wr_data[31:21], wr_data[15:13], wr_data[7:5]};
  assign cfg_out = {rx_bit, es_bit, a_misc, a_post, a_pre, a_diff};
  assign busy = state != IDLE;
  assign wr_ctrl = wr_en && wr_addr == 3'd2;
  assign commit = wr_ctrl && wr_data[0];
  assign es_req = wr_ctrl && wr_data[1];
  assign done = cnt == CW'(RST_CYCLES - 1);
  assign diff_w = wr_data[4:0] > DIFFCTRL_MAX ? DIFFCTRL_MAX : wr_data[4:0];
`ifdef GT_CFG_CTRL_AUTO_RXRESET_EN
  assign dfe_chg = s_misc[4] ^ a_misc[4];
`else
  assign dfe_chg = 1'b0;
`endif
  always_comb begin
    state_n = state == IDLE  ? (commit ? APPLY : es_req ? ES_RST : IDLE) :
              state == APPLY ? (dfe_chg ? RX_RST : IDLE) :
              done ? IDLE : state;
    ctrl_rx_n = wr_ctrl ? wr_data[2] : ctrl_rx;
    // a busy request or a commit+eyescan pair both lose a request; a new error beats W1C
    err_n = (wr_ctrl && ((busy && (wr_data[0] || wr_data[1])) || (!busy && wr_data[0] && wr_data[1]))) ||
            (err && !(wr_en && wr_addr == 3'd3 && wr_data[1]));
    rd_mux = rd_addr == 3'd0 ? {11'd0, s_post, 3'd0, s_pre, 3'd0, s_diff} :
             rd_addr == 3'd1 ? {27'd0, s_misc} :
             rd_addr == 3'd2 ? {29'd0, ctrl_rx, 2'd0} :
             rd_addr == 3'd3 ? {30'd0, err, busy} :
             rd_addr == 3'd4 ? {11'd0, a_post, 3'd0, a_pre, 3'd0, a_diff} :
             rd_addr == 3'd5 ? {27'd0, a_misc} : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_RST;
      cnt <= '0;
      {s_diff, s_pre, s_post, s_misc} <= {DIFFCTRL_RST, 10'd0, MISC_RST};
      {a_diff, a_pre, a_post, a_misc} <= {DIFFCTRL_RST, 10'd0, MISC_RST};
      rx_bit <= 1'b1;
      es_bit <= 1'b0;
      ctrl_rx <= 1'b0;
      err <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n == state && (state == RX_RST || state == ES_RST)) ? cnt + 1'b1 : '0;
      rx_bit <= (state_n == RX_RST) || ctrl_rx_n;
      es_bit <= state_n == ES_RST;
      ctrl_rx <= ctrl_rx_n;
      err <= err_n;
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
      if (wr_en && wr_addr == 3'd0) {s_post, s_pre, s_diff} <= {wr_data[20:16], wr_data[12:8], diff_w};
      if (wr_en && wr_addr == 3'd1) s_misc <= wr_data[4:0];
      if (state == APPLY) {a_diff, a_pre, a_post, a_misc} <= {s_diff, s_pre, s_post, s_misc};
    end
  end
endmodule

// File: tb/tb_gt_cfg_ctrl.sv
// tb_gt_cfg_ctrl: directed bench with a read scoreboard and inline cfg_out/timing checks
module tb_gt_cfg_ctrl;
  logic clk = 0, rst = 1, wr_en = 0, rd_en = 0;
  logic [2:0] wr_addr = 0, rd_addr = 0;
  logic [31:0] wr_data = 0, rd_data;
  logic rd_valid, busy;
  logic [21:0] cfg_out;
  int errs = 0, checks = 0;
  logic [31:0] exp_q[$];
`ifdef GT_CFG_CTRL_AUTO_RXRESET_EN
  localparam int DFE_RX = 16;
`else
  localparam int DFE_RX = 0;
`endif
  localparam logic [21:0] RST_CFG = {1'b1, 1'b0, 5'b10010, 5'd0, 5'd0, 5'd12};
  localparam logic [21:0] CFG1 = {1'b0, 1'b0, 5'b10011, 5'd3, 5'd2, 5'd24};
  localparam logic [21:0] CFG2 = {1'b0, 1'b0, 5'b00011, 5'd3, 5'd2, 5'd24};
  gt_cfg_ctrl dut (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
                   .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
                   .cfg_out(cfg_out), .busy(busy));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask
  task automatic rd(input logic [2:0] a, input logic [31:0] exp);
    rd_en = 1; rd_addr = a;
    exp_q.push_back(exp);
    tick();
    rd_en = 0;
  endtask
  task automatic wrrd(input logic [2:0] a, input logic [31:0] d, input logic [31:0] exp);
    wr_en = 1; wr_addr = a; wr_data = d; rd_en = 1; rd_addr = a;
    exp_q.push_back(exp);
    tick();
    wr_en = 0; rd_en = 0;
  endtask
  task automatic pulse_len(input int bit_i, input int start, output int n);
    n = start;
    while (cfg_out[bit_i] && n < 100) begin
      tick();
      n++;
    end
  endtask
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errs++;
        $display("FAIL rd_unexpected: got 0x%08h expected no read", rd_data);
      end else chk("rd_data", rd_data, exp_q.pop_front());
    end
  end
  initial begin
    int n;
    tick(); tick();
    chk("rst_cfg", 32'(cfg_out), 32'(RST_CFG));
    chk("rst_busy", 32'(busy), 1);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    rst = 0;
    pulse_len(21, 0, n);
    chk("rst_rx_len", n, 16);
    chk("post_rst_cfg", 32'(cfg_out), 32'(RST_CFG & ~(22'd1 << 21)));
    chk("post_rst_busy", 32'(busy), 0);
    rd(0, 32'h0000000C); rd(1, 32'h12); rd(2, 0); rd(3, 0); rd(4, 32'h0000000C); rd(5, 32'h12); rd(6, 0);
    wr(0, 32'h18); rd(0, 32'h18);
    wr(0, 32'h19); rd(0, 32'h18);
    wr(0, 32'h0003021F); rd(0, 32'h00030218); rd(4, 32'h0000000C);
    wrrd(1, 32'h13, 32'h12); rd(1, 32'h13);
    wr(2, 1);
    chk("apply_busy", 32'(busy), 1);
    chk("apply_cfg_old", 32'(cfg_out), 32'(RST_CFG & ~(22'd1 << 21)));
    tick();
    chk("commit_cfg", 32'(cfg_out), 32'(CFG1));
    chk("commit_busy", 32'(busy), 0);
    rd(4, 32'h00030218); rd(5, 32'h13);
    wr(1, 32'h03); wr(2, 1); tick();
    chk("dfe_cfg", 32'(cfg_out & ~(22'd1 << 21)), 32'(CFG2));
    chk("dfe_busy", 32'(busy), DFE_RX != 0 ? 1 : 0);
    pulse_len(21, 0, n);
    chk("dfe_rx_len", n, DFE_RX);
    rd(5, 32'h03);
    wr(2, 2);
    wr(2, 1);
    rd(3, 32'h3);
    pulse_len(20, 2, n);
    chk("es_len", n, 16);
    chk("es_no_commit", 32'(cfg_out), 32'(CFG2));
    rd(3, 32'h2); wr(3, 2); rd(3, 0);
    wr(2, 3);
    chk("both_busy", 32'(busy), 1);
    tick();
    chk("both_no_es", 32'(cfg_out[20]), 0);
    rd(3, 32'h2); wr(3, 2);
    wr(2, 4);
    chk("ctrl_rx_on", 32'(cfg_out[21]), 1);
    chk("ctrl_rx_idle", 32'(busy), 0);
    rd(2, 32'h4);
    wr(2, 0);
    chk("ctrl_rx_off", 32'(cfg_out[21]), 0);
    wr(2, 2);
    repeat (4) tick();
    chk("es_mid", 32'(cfg_out[20]), 1);
    rst = 1; tick();
    chk("midrst_cfg", 32'(cfg_out), 32'(RST_CFG));
    rst = 0;
    pulse_len(21, 0, n);
    chk("midrst_rx_len", n, 16);
    rd(0, 32'h0000000C); rd(3, 0);
    repeat (3) tick();
    chk("rd_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
